sp_port_arbiter: RTL and testbench
==================================

# sp_port_arbiter

Shares one Gowin SP single-port BSRAM (16-bit word mode) between a write stream and a read-request client. Serialises accesses with round-robin arbitration, formats the BSRAM address bus and tags read data with a fixed-latency response valid. Sits directly in front of an `SP` instance; the two clients never touch BSRAM pins.

## Interface
- `ADDR_WIDTH`, 10, word address width; fixed at 10 for 1024×16.
- `DATA_WIDTH`, 16, client data width; zero-extended to 32 bits on `ram_di`.
- `READ_LATENCY`, 1, cycles from granted read to `ram_do` valid. Use 1 for BSRAM `READ_MODE`=1 (bypass) and 2 for registered output; other values are illegal.

Ports:
- `clk`  in  1  single clock; also drives BSRAM `CLK`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write granted this cycle.
- `wr_addr`  in  ADDR_WIDTH  write word address.
- `wr_data`  in  DATA_WIDTH  write data.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read granted this cycle.
- `rd_addr`  in  ADDR_WIDTH  read word address.
- `rd_resp_valid`  out  1  read data valid, one-cycle pulse.
- `rd_resp_data`  out  DATA_WIDTH  read data.
- `busy`  out  1  high while not in RUN.
- `ram_ad`  out  14  to BSRAM `AD`, equal to {addr, 4'b0000}.
- `ram_di`  out  32  to BSRAM `DI`.
- `ram_do`  in  32  from BSRAM `DO`; only [DATA_WIDTH-1:0] is used.
- `ram_ce`, `ram_wre`, `ram_oce`, `ram_reset`  out  1 each  to BSRAM `CE`, `WRE`, `OCE`, `RESET`.

## Operation
- States: CLEAR and RUN.
  - CLEAR exists only with the configuration macro defined; otherwise the reset state is RUN.
- Arbitration in RUN:
  - Only one of `wr_valid`/`rd_valid` high: that requester is granted.
  - Both high: the requester not granted last is granted.
  - `last_grant` resets to "read", so the first contended cycle goes to write.
  - `last_grant` updates only on a grant.
- Readies are combinational from the valids and `last_grant`. `wr_ready` and `rd_ready` are never both high.
- A transfer occurs on `valid && ready` in the same cycle; there is no request buffering.
- Write grant drives `ram_ce`=1, `ram_wre`=1, `ram_ad`={wr_addr,4'b0}, `ram_di`={16'b0,wr_data}.
- Read grant drives `ram_ce`=1, `ram_wre`=0, `ram_ad`={rd_addr,4'b0}.
- No grant drives `ram_ce`=0, `ram_wre`=0, `ram_ad`=0 and `ram_di`=0.
- `ram_oce`=1 and `ram_reset`=0 always.
- Read response tracking:
  - A READ_LATENCY-deep valid shift register captures read grants.
  - `rd_resp_valid` is the last stage.
  - `rd_resp_data` = `ram_do[DATA_WIDTH-1:0]` when `rd_resp_valid`=1, else 0.
  - Responses return in grant order and cannot be back-pressured.
- Reset values: `wr_ready`=0, `rd_ready`=0, `rd_resp_valid`=0, `rd_resp_data`=0, `ram_ce`=0, `ram_wre`=0, `ram_ad`=0, `ram_di`=0, `ram_oce`=1, `ram_reset`=0, `busy`=1 with the macro or 0 without it, shift register all 0.

## Timing
- Grant and BSRAM drive happen in the same cycle, with no added latency.
- A read granted at edge N has `rd_resp_valid` high in the cycle after edge N+READ_LATENCY.
- Sustained throughput is one access per cycle.
- Under contention each side gets every other cycle.
- Read-after-write to the same address on consecutive grants returns the new data, because BSRAM NORMAL write mode commits at the write edge.
- A write granted while an earlier read is still in the pipe does not disturb that read's data.
- Reset asserted mid-operation:
  - Pending responses are dropped; no `rd_resp_valid` appears after release.
  - CLEAR restarts from address 0 when the macro is defined.

## Configuration
- `SP_ARB_CLEAR_EN` defined:
  - After reset, state CLEAR writes 0 to addresses 0..1023, one per cycle: `ram_ce`=1, `ram_wre`=1.
  - `busy`=1 and both readies are 0 during CLEAR.
  - RUN is entered after the write to address 1023.
  - `busy` falls on the cycle after that write, i.e. 1024 cycles after reset release.
- `SP_ARB_CLEAR_EN` undefined: RUN directly from reset, `busy` constant 0, no clear counter.

## Test plan
- Write only: 4 writes of 0xA5A0..0xA5A3 to addresses 0..3 -> `wr_ready` high all 4 cycles, `ram_ad`=0x0000, 0x0010, 0x0020, 0x0030, `ram_wre`=1.
- Read back: reads of addresses 0..3 at READ_LATENCY=1 -> `rd_resp_valid` one cycle after each grant, data 0xA5A0..0xA5A3 in order; repeat at READ_LATENCY=2 with a registered-mode SP.
- Contention: `wr_valid` and `rd_valid` held high for 6 cycles -> grants W,R,W,R,W,R, never both readies high.
- Read-after-write: write 0x1234 to address 0x3FF, read 0x3FF on the next cycle -> response 0x1234.
- Reset mid-read: `rst_n` low one cycle after a read grant -> no `rd_resp_valid`, all outputs at reset values.
- With `SP_ARB_CLEAR_EN`: preload address 5 with 0xFFFF, then reset -> `busy` high 1024 cycles, readies 0 throughout, read of address 5 returns 0x0000.

Source files
------------

// File: rtl/sp_port_arbiter_if.sv
// Client handshake and BSRAM pin bundle for sp_port_arbiter.
// slave = arbiter side, master = clients plus the SP primitive.
interface sp_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_resp_valid;
  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic                  busy;
  logic [ADDR_WIDTH+3:0] ram_ad;
  logic [31:0]           ram_di;
  logic [31:0]           ram_do;
  logic                  ram_ce;
  logic                  ram_wre;
  logic                  ram_oce;
  logic                  ram_reset;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_do,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data, busy,
           ram_ad, ram_di, ram_ce, ram_wre, ram_oce, ram_reset
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_do,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data, busy,
           ram_ad, ram_di, ram_ce, ram_wre, ram_oce, ram_reset
  );
endinterface

// File: rtl/sp_port_arbiter.sv
// Round-robin write/read arbiter in front of a Gowin SP BSRAM (16-bit mode).
// Optional SP_ARB_CLEAR_EN: zero-fill all 1024 words after reset before RUN.
module sp_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1   // 1 = bypass output, 2 = registered output
)(
  input  logic            clk,
  input  logic            rst_n,
  sp_port_arbiter_if.slave bus
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q;
  logic                    run;
  logic                    wr_gnt, rd_gnt;
  logic                    last_rd_q, last_rd_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic                    unused_do;

`ifdef SP_ARB_CLEAR_EN
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
  logic                    clr_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_wr     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_wr     = rst_n;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (&clr_addr_q) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign bus.busy = (state_q != RUN);
`else
  assign state_q  = RUN;
  assign bus.busy = 1'b0;
`endif

  // Grants are held off while reset is asserted so outputs sit at reset values.
  assign run    = (state_q == RUN) && rst_n;
  assign wr_gnt = run && bus.wr_valid && (!bus.rd_valid || last_rd_q);
  assign rd_gnt = run && bus.rd_valid && !wr_gnt;

  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;

  always_comb begin
    last_rd_d = last_rd_q;
    if (wr_gnt)      last_rd_d = 1'b0;
    else if (rd_gnt) last_rd_d = 1'b1;
  end

  assign vld_pipe_d = READ_LATENCY'({vld_pipe_q, rd_gnt});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q  <= 1'b1;
      vld_pipe_q <= '0;
    end else begin
      last_rd_q  <= last_rd_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  always_comb begin
    bus.ram_ce  = 1'b0;
    bus.ram_wre = 1'b0;
    bus.ram_ad  = '0;
    bus.ram_di  = '0;
`ifdef SP_ARB_CLEAR_EN
    if (clr_wr) begin
      bus.ram_ce  = 1'b1;
      bus.ram_wre = 1'b1;
      bus.ram_ad  = {clr_addr_q, 4'b0000};
    end
`endif
    if (wr_gnt) begin
      bus.ram_ce  = 1'b1;
      bus.ram_wre = 1'b1;
      bus.ram_ad  = {bus.wr_addr, 4'b0000};
      bus.ram_di  = {{(32-DATA_WIDTH){1'b0}}, bus.wr_data};
    end else if (rd_gnt) begin
      bus.ram_ce  = 1'b1;
      bus.ram_ad  = {bus.rd_addr, 4'b0000};
    end
  end

  assign bus.ram_oce   = 1'b1;
  assign bus.ram_reset = 1'b0;

  assign bus.rd_resp_valid = vld_pipe_q[READ_LATENCY-1];
  assign bus.rd_resp_data  = vld_pipe_q[READ_LATENCY-1] ? bus.ram_do[DATA_WIDTH-1:0] : '0;

  assign unused_do = ^bus.ram_do[31:DATA_WIDTH];

endmodule

// File: tb/tb_sp_port_arbiter.sv
// Scoreboard bench: two arbiters (bypass and registered BSRAM) driven in lockstep.
module tb_sp_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef SP_ARB_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  typedef struct {logic [15:0] data; int due;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic last_rd;
  logic [15:0] mem_ref [1024];
  logic [15:0] mem1 [1024];
  logic [15:0] mem2 [1024];
  logic [15:0] do1 = '0, do2a = '0, do2b = '0;
  exp_t q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1();
  sp_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2();

  sp_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  sp_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // SP models, NORMAL write mode: DO holds during writes
  always @(posedge clk) begin
    if (b1.ram_ce) begin
      if (b1.ram_wre) mem1[b1.ram_ad[13:4]] <= b1.ram_di[15:0];
      else            do1 <= mem1[b1.ram_ad[13:4]];
    end
    if (b2.ram_ce) begin
      if (b2.ram_wre) mem2[b2.ram_ad[13:4]] <= b2.ram_di[15:0];
      else            do2a <= mem2[b2.ram_ad[13:4]];
    end
    if (b2.ram_oce) do2b <= do2a;
  end
  assign b1.ram_do = {16'h0, do1};
  assign b2.ram_do = {16'h0, do2b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [15:0] d);
    exp_t e;
    if (v) begin
      if (q[k].size() == 0) chk($sformatf("dut%0d unexpected rd_resp_valid", k+1), {31'h0, v}, 32'h0);
      else begin
        e = q[k].pop_front();
        chk($sformatf("dut%0d rd_resp_data", k+1), {16'h0, d}, {16'h0, e.data});
        chk($sformatf("dut%0d rd_resp cycle", k+1), cyc, e.due);
      end
    end else begin
      chk($sformatf("dut%0d rd_resp_data idle", k+1), {16'h0, d}, 32'h0);
      if (q[k].size() > 0 && q[k][0].due <= cyc) begin
        e = q[k].pop_front();
        chk($sformatf("dut%0d missing rd_resp_valid", k+1), {31'h0, v}, 32'h1);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      mon(0, b1.rd_resp_valid, b1.rd_resp_data);
      mon(1, b2.rd_resp_valid, b2.rd_resp_data);
    end
  end

  task automatic set_in(input logic wv, input logic [9:0] wa, input logic [15:0] wd,
                        input logic rv, input logic [9:0] ra);
    b1.wr_valid = wv; b1.wr_addr = wa; b1.wr_data = wd; b1.rd_valid = rv; b1.rd_addr = ra;
    b2.wr_valid = wv; b2.wr_addr = wa; b2.wr_data = wd; b2.rd_valid = rv; b2.rd_addr = ra;
  endtask

  // One cycle of client activity; expected grant and bus derived from the arbitration rules.
  task automatic drive(input logic wv, input logic [9:0] wa, input logic [15:0] wd,
                       input logic rv, input logic [9:0] ra);
    logic ew, er;
    logic [13:0] ead;
    logic [31:0] edi;
    @(negedge clk);
    set_in(wv, wa, wd, rv, ra);
    #1;
    ew  = wv && (!rv || last_rd);
    er  = rv && !ew;
    ead = ew ? {wa, 4'h0} : (er ? {ra, 4'h0} : 14'h0);
    edi = ew ? {16'h0, wd} : 32'h0;
    chk("dut1 wr_ready", {31'h0, b1.wr_ready}, {31'h0, ew});
    chk("dut1 rd_ready", {31'h0, b1.rd_ready}, {31'h0, er});
    chk("dut1 ram_ce",   {31'h0, b1.ram_ce},   {31'h0, ew | er});
    chk("dut1 ram_wre",  {31'h0, b1.ram_wre},  {31'h0, ew});
    chk("dut1 ram_ad",   {18'h0, b1.ram_ad},   {18'h0, ead});
    chk("dut1 ram_di",   b1.ram_di, edi);
    chk("dut2 wr_ready", {31'h0, b2.wr_ready}, {31'h0, ew});
    chk("dut2 rd_ready", {31'h0, b2.rd_ready}, {31'h0, er});
    chk("dut2 ram_ad",   {18'h0, b2.ram_ad},   {18'h0, ead});
    if (ew) begin
      mem_ref[wa] = wd;
      last_rd = 1'b0;
    end
    if (er) begin
      q[0].push_back('{data: mem_ref[ra], due: cyc + 1});
      q[1].push_back('{data: mem_ref[ra], due: cyc + 2});
      last_rd = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1'b1, 10'h155, 16'hBEEF, 1'b1, 10'h2AA);
    #1;
    chk("rst wr_ready",      {31'h0, b1.wr_ready},      32'h0);
    chk("rst rd_ready",      {31'h0, b1.rd_ready},      32'h0);
    chk("rst dut1 resp_vld", {31'h0, b1.rd_resp_valid}, 32'h0);
    chk("rst dut2 resp_vld", {31'h0, b2.rd_resp_valid}, 32'h0);
    chk("rst resp_data",     {16'h0, b2.rd_resp_data},  32'h0);
    chk("rst ram_ce",        {31'h0, b1.ram_ce},        32'h0);
    chk("rst ram_wre",       {31'h0, b1.ram_wre},       32'h0);
    chk("rst ram_ad",        {18'h0, b1.ram_ad},        32'h0);
    chk("rst ram_di",        b1.ram_di,                 32'h0);
    chk("rst ram_oce",       {31'h0, b1.ram_oce},       32'h1);
    chk("rst ram_reset",     {31'h0, b1.ram_reset},     32'h0);
    chk("rst busy",          {31'h0, b1.busy},          {31'h0, BUSY_RST});
    q[0].delete();
    q[1].delete();
    last_rd = 1'b1;
    repeat (2) @(negedge clk);
    set_in(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    rst_n = 1'b1;
`ifdef SP_ARB_CLEAR_EN
    for (int i = 0; i < 1024; i++) mem_ref[i] = 16'h0;
    set_in(1'b1, 10'h5, 16'h5555, 1'b1, 10'h5);
    n = 0;
    #1;
    while (b1.busy && n < 3000) begin
      if (b1.wr_ready || b1.rd_ready) chk("ready during CLEAR", 32'h1, 32'h0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy cycles after release", n, 1024);
    set_in(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
`else
    n = 0;
    #1;
    chk("busy after release", {31'h0, b1.busy}, 32'h0);
    chk("busy cycles after release", n, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_ref[i] = 16'h0; mem1[i] = 16'h0; mem2[i] = 16'h0;
    end
    last_rd = 1'b1;
    set_in(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    do_reset();

    // contention straight out of reset: W,R,W,R,W,R
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 10'(i), 16'hC000 + 16'(i), 1'b1, 10'(i + 8));
      chk("contention order", {31'h0, b1.wr_ready}, {31'h0, (i % 2 == 0)});
    end
    idle(3);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 10'(i), 16'hA5A0 + 16'(i), 1'b0, 10'h0);
      chk("write-only ram_ad", {18'h0, b1.ram_ad}, 32'(i * 16));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 10'h0, 16'h0, 1'b1, 10'(i));
    idle(3);

    drive(1'b1, 10'h3FF, 16'h1234, 1'b0, 10'h0);
    drive(1'b0, 10'h0, 16'h0, 1'b1, 10'h3FF);
    // write lands while the previous read is still in the registered pipe
    drive(1'b1, 10'h3FF, 16'h9999, 1'b0, 10'h0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [9:0] wa, ra;
      wa = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      ra = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), wa, 16'($urandom), 1'($urandom_range(0, 1)), ra);
    end
    idle(3);

    drive(1'b0, 10'h0, 16'h0, 1'b1, 10'h3);
    do_reset();
    idle(6);
    drive(1'b0, 10'h0, 16'h0, 1'b1, 10'h3FF);
    idle(4);

    chk("pending responses", 32'(q[0].size() + q[1].size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
